// File: rtl/lsu_store_drain_pkg.sv
// Shared LSU drain types: FIFO entry layout, drain FSM states and sizing defaults.
package lsu_store_drain_pkg;

    localparam int LSU_ADDR_WIDTH      = 32;
    localparam int LSU_DATA_WIDTH      = 64;
    localparam int LSU_SSID_WIDTH      = 8;
    localparam int LSU_DRAIN_DEPTH     = 8;
    localparam int LSU_MAX_OUTSTANDING = 4;

    typedef struct packed {
        logic                      valid;
        logic [LSU_ADDR_WIDTH-1:0] addr;
        logic [LSU_DATA_WIDTH-1:0] data;
        logic [LSU_SSID_WIDTH-1:0] ssid;
    } drain_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FLUSH = 2'd2
    } drain_state_e;

endpackage

// File: rtl/lsu_store_drain_fwd_cam.sv
// Combinational store-to-load forwarding search: youngest valid entry whose address
// matches the probe wins; data is zero on a miss.
module lsu_drain_fwd_cam #(
    parameter  int ADDR_WIDTH  = 32,
    parameter  int DATA_WIDTH  = 64,
    parameter  int DRAIN_DEPTH = 8,
    localparam int IDX_W       = $clog2(DRAIN_DEPTH)
) (
    input  logic [DRAIN_DEPTH-1:0]                 ent_valid_i,
    input  logic [DRAIN_DEPTH-1:0][ADDR_WIDTH-1:0] ent_addr_i,
    input  logic [DRAIN_DEPTH-1:0][DATA_WIDTH-1:0] ent_data_i,
    input  logic [IDX_W-1:0]                       head_idx_i,
    input  logic [ADDR_WIDTH-1:0]                  probe_addr_i,
    output logic                                   hit_o,
    output logic [DATA_WIDTH-1:0]                  data_o
);

    logic [IDX_W-1:0] age_idx;

    // Walk oldest to youngest starting at the head so the last match is the youngest.
    always_comb begin
        hit_o   = 1'b0;
        data_o  = '0;
        age_idx = '0;
        for (int i = 0; i < DRAIN_DEPTH; i++) begin
            age_idx = head_idx_i + IDX_W'(i);
            if (ent_valid_i[age_idx] && (ent_addr_i[age_idx] == probe_addr_i)) begin
                hit_o  = 1'b1;
                data_o = ent_data_i[age_idx];
            end
        end
    end

endmodule

// File: rtl/lsu_store_drain.sv
// Retired-store drain buffer between LSQ commit and the L1 write port, with forwarding,
// ssid release and flush handshake. Optional tail coalescing under LSU_DRAIN_COALESCE_EN.
module lsu_store_drain
    import lsu_store_drain_pkg::*;
#(
    parameter int ADDR_WIDTH      = LSU_ADDR_WIDTH,
    parameter int DATA_WIDTH      = LSU_DATA_WIDTH,
    parameter int DRAIN_DEPTH     = LSU_DRAIN_DEPTH,
    parameter int MAX_OUTSTANDING = LSU_MAX_OUTSTANDING
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  commit_valid,
    output logic                  commit_ready,
    input  logic [ADDR_WIDTH-1:0] commit_addr,
    input  logic [DATA_WIDTH-1:0] commit_data,
    input  logic [7:0]            commit_ssid,
    output logic                  mem_wr_valid,
    input  logic                  mem_wr_ready,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic                  mem_wr_ack,
    input  logic [ADDR_WIDTH-1:0] ld_probe_addr,
    output logic                  fwd_hit,
    output logic [DATA_WIDTH-1:0] fwd_data,
    output logic                  ssid_release_valid,
    output logic [7:0]            ssid_release,
    input  logic                  flush_req,
    output logic                  drain_done,
    output logic [31:0]           stores_drained,
    output logic                  err_unexpected_ack
);

    localparam int IDX_W = $clog2(DRAIN_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [DRAIN_DEPTH-1:0]                 ent_valid_q;
    logic [DRAIN_DEPTH-1:0][ADDR_WIDTH-1:0] ent_addr_q;
    logic [DRAIN_DEPTH-1:0][DATA_WIDTH-1:0] ent_data_q;
    logic [DRAIN_DEPTH-1:0][7:0]            ent_ssid_q;

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_d;
    logic [IDX_W-1:0]      wr_idx, rd_idx, rd_idx_d;
    logic                  full_q, full_d, empty_d;
    logic [OUT_W-1:0]      out_q, out_d;
    drain_state_e          state_q;
    logic                  drain_done_q;
    logic                  wr_valid_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q, head_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, head_data_d;
    logic                  rel_valid_q;
    logic [7:0]            rel_ssid_q;
    logic [31:0]           drained_q;
    logic                  err_q;
    logic                  accept, coalesce, push, pop, ack_ok, issue_d;

    assign wr_idx       = wr_ptr_q[IDX_W-1:0];
    assign rd_idx       = rd_ptr_q[IDX_W-1:0];
    assign commit_ready = !full_q && (state_q != FLUSH);
    assign accept       = commit_valid && commit_ready;

`ifdef LSU_DRAIN_COALESCE_EN
    logic [IDX_W-1:0] tail_idx;
    assign tail_idx = wr_idx - IDX_W'(1);
    // The entry on the write port is frozen, so it can never absorb a newer store.
    assign coalesce = accept && ent_valid_q[tail_idx] && (ent_addr_q[tail_idx] == commit_addr)
                      && !(wr_valid_q && (tail_idx == rd_idx));
`else
    assign coalesce = 1'b0;
`endif

    assign push     = accept && !coalesce;
    assign pop      = wr_valid_q && mem_wr_ready;
    assign ack_ok   = mem_wr_ack && (out_q != '0);
    assign wr_ptr_d = wr_ptr_q + PTR_W'(push);
    assign rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    assign rd_idx_d = rd_ptr_d[IDX_W-1:0];
    assign count_d  = wr_ptr_d - rd_ptr_d;
    assign full_d   = (count_d == PTR_W'(DRAIN_DEPTH));
    assign empty_d  = (count_d == '0);
    assign out_d    = out_q + OUT_W'(pop) - OUT_W'(ack_ok);
    assign issue_d  = !empty_d && (out_d < OUT_W'(MAX_OUTSTANDING));

    // Next head payload, bypassing a store that lands in the head slot this cycle.
    always_comb begin
        head_addr_d = ent_addr_q[rd_idx_d];
        head_data_d = ent_data_q[rd_idx_d];
        if (push && (rd_ptr_d == wr_ptr_q)) begin
            head_addr_d = commit_addr;
            head_data_d = commit_data;
        end
`ifdef LSU_DRAIN_COALESCE_EN
        if (coalesce && (tail_idx == rd_idx_d)) begin
            head_data_d = commit_data;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr_q[wr_idx] <= commit_addr;
            ent_data_q[wr_idx] <= commit_data;
            ent_ssid_q[wr_idx] <= commit_ssid;
        end
`ifdef LSU_DRAIN_COALESCE_EN
        if (coalesce) begin
            ent_data_q[tail_idx] <= commit_data;
            ent_ssid_q[tail_idx] <= commit_ssid;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_valid_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            full_q      <= 1'b0;
            out_q       <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rel_valid_q <= 1'b0;
            rel_ssid_q  <= '0;
            drained_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            if (push) ent_valid_q[wr_idx] <= 1'b1;
            if (pop)  ent_valid_q[rd_idx] <= 1'b0;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            full_q      <= full_d;
            out_q       <= out_d;
            drained_q   <= drained_q + 32'(pop);
            rel_valid_q <= pop;
            if (pop) rel_ssid_q <= ent_ssid_q[rd_idx];
            if (mem_wr_ack && (out_q == '0)) err_q <= 1'b1;
            // Payload is held while the port stalls; reload only once it is free.
            if (!wr_valid_q || pop) begin
                wr_valid_q <= issue_d;
                if (issue_d) begin
                    wr_addr_q <= head_addr_d;
                    wr_data_q <= head_data_d;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            drain_done_q <= 1'b0;
        end else begin
            drain_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (flush_req)  state_q <= FLUSH;
                    else if (push)  state_q <= ISSUE;
                end
                ISSUE: begin
                    if (flush_req)    state_q <= FLUSH;
                    else if (empty_d) state_q <= IDLE;
                end
                FLUSH: begin
                    if (empty_d && (out_d == '0)) begin
                        drain_done_q <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    lsu_drain_fwd_cam #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DRAIN_DEPTH(DRAIN_DEPTH)
    ) u_fwd_cam (
        .ent_valid_i (ent_valid_q),
        .ent_addr_i  (ent_addr_q),
        .ent_data_i  (ent_data_q),
        .head_idx_i  (rd_idx),
        .probe_addr_i(ld_probe_addr),
        .hit_o       (fwd_hit),
        .data_o      (fwd_data)
    );

    assign mem_wr_valid       = wr_valid_q;
    assign mem_wr_addr        = wr_addr_q;
    assign mem_wr_data        = wr_data_q;
    assign ssid_release_valid = rel_valid_q;
    assign ssid_release       = rel_ssid_q;
    assign drain_done         = drain_done_q;
    assign stores_drained     = drained_q;
    assign err_unexpected_ack = err_q;

endmodule
